// File: rtl/t03_player_pkg.sv
// Shared player geometry and motion-state definitions.
// Purpose : one place where the motion blocks and the display blocks agree
//           on sprite geometry, screen offsets and the vertical state set.
// Contents: player_state_t (vertical motion state), sprite size constants,
//           screen offsets.
package t03_player_pkg;

  // Vertical motion state. Horizontal motion has no state of its own.
  typedef enum logic [1:0] {
    GROUNDED = 2'd0,
    RISING   = 2'd1,
    FALLING  = 2'd2
  } player_state_t;

  // Sprite geometry in screen pixels / lines.
  localparam int SPRITE_W = 15;
  localparam int SPRITE_H = 20;
  localparam int V_SCALE  = 5;

  // Offsets the display stage adds to x/y before comparing with Hcnt/Vcnt.
  localparam int SCREEN_X_OFF = 37;
  localparam int SCREEN_Y_OFF = 29;

endpackage

// File: rtl/frame_tick_gen.sv
// Per-frame tick generator.
// Purpose : emits a single-cycle pulse the cycle after Vcnt first equals
//           FRAME_LINE, however many clk cycles Vcnt holds that value.
// Ports   : clk, rst (sync, active-high), vcnt_i (VGA vertical counter),
//           tick_o (registered one-cycle pulse).
module frame_tick_gen #(
  parameter int FRAME_LINE = 481
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] vcnt_i,
  output logic        tick_o
);

  logic match;
  logic match_q;
  logic tick_q;

  assign match = (vcnt_i == 11'(FRAME_LINE));

  // match_q resets to 1 so a Vcnt already sitting on FRAME_LINE when reset
  // drops does not produce a spurious tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_q <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      match_q <= match;
      tick_q  <= match & ~match_q;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/player_1_motion.sv
// Player 1 motion: sprite position generator feeding player_1_display.
// Purpose : once per video frame (vblank tick) samples the buttons, walks
//           the sprite horizontally with clamping at the screen edges, and
//           runs a jump/gravity state machine for y. x/y only change on the
//           cycle after a tick, so they never move during active video.
// Ports   : clk, rst (sync, active-high)
//           Hcnt (reserved, unused), Vcnt (VGA vertical counter)
//           btn_left/btn_right/btn_jump (synchronised level inputs)
//           x, y (sprite position), facing_left, airborne, frame_tick
//           state_dbg_o (vertical state), vel_dbg_o (vertical speed)
// Handshake: frame_tick acts as the valid strobe for motion updates; there
//           is no ready, a tick is always accepted, and the new x/y/state
//           are visible on the cycle after the tick.
module player_1_motion
  import t03_player_pkg::*;
#(
  parameter int FRAME_LINE = 481,
  parameter int X_INIT     = 100,
  parameter int X_MAX      = 588,
  parameter int X_SPEED    = 2,
  parameter int FLOOR_Y    = 300,
  parameter int JUMP_V     = 12,
  parameter int GRAVITY    = 1,
  parameter int MAX_FALL   = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] Hcnt,
  input  logic [10:0] Vcnt,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_jump,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        facing_left,
  output logic        airborne,
  output logic        frame_tick,
  output logic [1:0]  state_dbg_o,
  output logic [5:0]  vel_dbg_o
);

  localparam logic [11:0] X_MAX_W    = 12'(X_MAX);
  localparam logic [11:0] X_SPEED_W  = 12'(X_SPEED);
  localparam logic [11:0] FLOOR_Y_W  = 12'(FLOOR_Y);
  localparam logic [5:0]  JUMP_V_W   = 6'(JUMP_V);
  localparam logic [5:0]  GRAVITY_W  = 6'(GRAVITY);
  localparam logic [6:0]  MAX_FALL_W = 7'(MAX_FALL);

  // Hcnt is kept on the port list for a uniform player block interface.
  logic unused_hcnt;
  assign unused_hcnt = ^Hcnt;

  logic tick;

  frame_tick_gen #(
    .FRAME_LINE(FRAME_LINE)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .vcnt_i(Vcnt),
    .tick_o(tick)
  );

  player_state_t state_q, state_d;
  logic [10:0]   x_q, x_d;
  logic [10:0]   y_q, y_d;
  logic [5:0]    vel_q, vel_d;
  logic          facing_q, facing_d;
  logic          airborne_q, airborne_d;
  logic          jump_req_q, jump_req_d;

  // Horizontal and vertical candidates computed one bit wider than the
  // registers so that under/overflow shows up before clamping.
  logic [11:0] x_left, x_right;
  logic [11:0] y_up, y_down;
  logic [6:0]  vel_sum;
  logic [5:0]  fall_vel;
  logic        jump_eff;

  assign x_left   = {1'b0, x_q} - X_SPEED_W;
  assign x_right  = {1'b0, x_q} + X_SPEED_W;
  assign y_up     = {1'b0, y_q} - {6'b0, vel_q};
  assign vel_sum  = {1'b0, vel_q} + {1'b0, GRAVITY_W};
  assign fall_vel = (vel_sum > MAX_FALL_W) ? MAX_FALL_W[5:0] : vel_sum[5:0];
  assign y_down   = {1'b0, y_q} + {6'b0, fall_vel};
  // A press on the tick cycle itself counts for that tick.
  assign jump_eff = jump_req_q | btn_jump;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= GROUNDED;
      x_q        <= 11'(X_INIT);
      y_q        <= 11'(FLOOR_Y);
      vel_q      <= 6'd0;
      facing_q   <= 1'b0;
      airborne_q <= 1'b0;
      jump_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      vel_q      <= vel_d;
      facing_q   <= facing_d;
      airborne_q <= airborne_d;
      jump_req_q <= jump_req_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    vel_d      = vel_q;
    facing_d   = facing_q;
    jump_req_d = jump_req_q | btn_jump;

    if (tick) begin
      // Every tick either consumes the request or, when airborne, drops it
      // so that presses during flight are not buffered.
      jump_req_d = 1'b0;

      if (btn_left && !btn_right) begin
        x_d      = x_left[11] ? 11'd0 : x_left[10:0];
        facing_d = 1'b1;
      end else if (btn_right && !btn_left) begin
        x_d      = (x_right > X_MAX_W) ? X_MAX_W[10:0] : x_right[10:0];
        facing_d = 1'b0;
      end

      unique case (state_q)
        GROUNDED: begin
          if (jump_eff) begin
            state_d = RISING;
            vel_d   = JUMP_V_W;
          end
        end
        RISING: begin
          if ({5'b0, vel_q} >= y_q) begin
            // Ceiling: clamp at the top of the screen and start falling.
            y_d     = 11'd0;
            vel_d   = 6'd0;
            state_d = FALLING;
          end else begin
            y_d = y_up[10:0];
            if (vel_q <= GRAVITY_W) begin
              vel_d   = 6'd0;
              state_d = FALLING;
            end else begin
              vel_d = vel_q - GRAVITY_W;
            end
          end
        end
        FALLING: begin
          if (y_down >= FLOOR_Y_W) begin
            y_d     = FLOOR_Y_W[10:0];
            vel_d   = 6'd0;
            state_d = GROUNDED;
          end else begin
            y_d   = y_down[10:0];
            vel_d = fall_vel;
          end
        end
        default: begin
          state_d = GROUNDED;
          vel_d   = 6'd0;
        end
      endcase
    end

    airborne_d = (state_d != GROUNDED);
  end

  assign x           = x_q;
  assign y           = y_q;
  assign facing_left = facing_q;
  assign airborne    = airborne_q;
  assign frame_tick  = tick;
  assign state_dbg_o = state_q;
  assign vel_dbg_o   = vel_q;

endmodule

// File: tb/tb_player_1_motion.sv
// Bench for player_1_motion: directed scenarios plus random frames, checked
// against a frame-level reference model through an expected-value queue.
module tb_player_1_motion;

  logic        clk;
  logic        rst;
  logic [10:0] Hcnt;
  logic [10:0] Vcnt;
  logic        btn_left, btn_right, btn_jump;
  logic [10:0] x, y;
  logic        facing_left, airborne, frame_tick;
  logic [1:0]  state_dbg;
  logic [5:0]  vel_dbg;

  player_1_motion dut (
    .clk        (clk),
    .rst        (rst),
    .Hcnt       (Hcnt),
    .Vcnt       (Vcnt),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_jump   (btn_jump),
    .x          (x),
    .y          (y),
    .facing_left(facing_left),
    .airborne   (airborne),
    .frame_tick (frame_tick),
    .state_dbg_o(state_dbg),
    .vel_dbg_o  (vel_dbg)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model (frame level) ----------------
  localparam int PH_GROUND = 0;
  localparam int PH_UP     = 1;
  localparam int PH_DOWN   = 2;

  int m_x, m_y, m_vel, m_phase;
  bit m_face, m_jreq;

  // Packed expectation: x, y, vel, phase, facing, airborne.
  logic [31:0] exp_q[$];

  function automatic logic [31:0] pack_exp();
    return {11'(m_x), 11'(m_y), 6'(m_vel), 2'(m_phase), m_face, (m_phase != PH_GROUND)};
  endfunction

  task automatic model_reset();
    m_x = 100; m_y = 300; m_vel = 0; m_phase = PH_GROUND; m_face = 0; m_jreq = 0;
  endtask

  // One frame: buttons as seen on the tick cycle.
  task automatic model_frame(input bit l, input bit r, input bit j);
    bit want_jump;
    want_jump = m_jreq || j;
    if (l && !r) begin
      m_x = (m_x - 2 < 0) ? 0 : m_x - 2;
      m_face = 1;
    end else if (r && !l) begin
      m_x = (m_x + 2 > 588) ? 588 : m_x + 2;
      m_face = 0;
    end
    if (m_phase == PH_GROUND) begin
      if (want_jump) begin m_phase = PH_UP; m_vel = 12; end
    end else if (m_phase == PH_UP) begin
      if (m_y <= m_vel) begin
        m_y = 0; m_vel = 0; m_phase = PH_DOWN;
      end else begin
        m_y = m_y - m_vel;
        if (m_vel <= 1) begin m_vel = 0; m_phase = PH_DOWN; end
        else m_vel = m_vel - 1;
      end
    end else begin
      m_vel = (m_vel + 1 > 12) ? 12 : m_vel + 1;
      if (m_y + m_vel >= 300) begin m_y = 300; m_vel = 0; m_phase = PH_GROUND; end
      else m_y = m_y + m_vel;
    end
    m_jreq = 0;
    exp_q.push_back(pack_exp());
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit          chk_pending = 0;
  int          tick_cnt = 0;
  int          tick_cyc = 0;
  logic [31:0] got, want;

  always @(negedge clk) begin
    if (rst) begin
      chk_pending = 0;
    end else begin
      if (chk_pending) begin
        got = {x, y, vel_dbg, state_dbg, facing_left, airborne};
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_tick: DUT x=%0d y=%0d with no expectation queued", x, y);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            n_fail++;
            $display("FAIL frame_update @cyc %0d: got x=%0d y=%0d vel=%0d st=%0d face=%0b air=%0b, want x=%0d y=%0d vel=%0d st=%0d face=%0b air=%0b",
                     cyc, got[31:21], got[20:10], got[9:4], got[3:2], got[1], got[0],
                     want[31:21], want[20:10], want[9:4], want[3:2], want[1], want[0]);
          end
        end
      end
      chk_pending = frame_tick;
      if (frame_tick) begin
        tick_cnt++;
        tick_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  // Drive one frame: buttons held across the tick, Vcnt on FRAME_LINE for
  // hold cycles, then released. Returns after the update has been checked.
  task automatic do_frame(input bit l, input bit r, input bit j, input int hold);
    @(negedge clk);
    btn_left = l; btn_right = r; btn_jump = j;
    Vcnt = 11'd481;
    model_frame(l, r, j);
    repeat (hold) @(negedge clk);
    Vcnt = 11'd0;
    repeat (3) @(negedge clk);
    btn_left = 0; btn_right = 0; btn_jump = 0;
    // Jump held past the tick re-arms the request for the next frame.
    m_jreq = j;
    @(negedge clk);
  endtask

  task automatic pulse_jump();
    @(negedge clk);
    btn_jump = 1;
    @(negedge clk);
    btn_jump = 0;
    m_jreq = 1;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1;
    repeat (cycles) @(negedge clk);
    rst = 0;
    model_reset();
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  int base_ticks, set_cyc, frames, min_y, y_after13;

  initial begin
    rst = 1; Hcnt = 0; Vcnt = 0; btn_left = 0; btn_right = 0; btn_jump = 0;
    model_reset();

    // Reset state
    do_reset(2);
    @(negedge clk);
    check("reset_x", x, 100);
    check("reset_y", y, 300);
    check("reset_airborne", airborne, 0);
    check("reset_facing", facing_left, 0);
    check("reset_tick", frame_tick, 0);
    check("reset_vel", vel_dbg, 0);

    // Tick uniqueness with Vcnt parked on the frame line
    base_ticks = tick_cnt;
    @(negedge clk);
    Vcnt = 11'd481;
    set_cyc = cyc;
    model_frame(0, 0, 0);
    repeat (800) @(negedge clk);
    Vcnt = 11'd0;
    repeat (3) @(negedge clk);
    check("tick_count_800", tick_cnt - base_ticks, 1);
    check("tick_latency_cyc", tick_cyc, set_cyc + 1);

    // Walk right into the clamp, then both buttons
    for (int i = 0; i < 300; i++) do_frame(0, 1, 0, 1 + (i % 3));
    check("walk_right_sat", x, 588);
    check("walk_right_face", facing_left, 0);
    do_frame(1, 1, 0, 2);
    do_frame(1, 1, 0, 1);
    check("both_hold_x", x, 588);

    // Walk left into the clamp
    for (int i = 0; i < 300; i++) do_frame(1, 0, 0, 1 + (i % 4));
    check("walk_left_sat", x, 0);
    check("walk_left_face", facing_left, 1);

    // Full jump with a single-cycle press between ticks
    pulse_jump();
    do_frame(0, 0, 0, 2);
    check("jump_start_state", state_dbg, 1);
    check("jump_start_y", y, 300);
    frames = 1; min_y = 300; y_after13 = -1;
    while (airborne && frames < 40) begin
      do_frame(0, 0, 0, 1);
      frames++;
      if (y < min_y) min_y = y;
      if (frames == 13) y_after13 = y;
    end
    check("jump_air_ticks", frames, 25);
    check("jump_apex", min_y, 222);
    check("jump_apex_at_13", y_after13, 222);
    check("jump_land_y", y, 300);
    check("jump_land_air", airborne, 0);

    // Press during flight is not buffered
    pulse_jump();
    do_frame(0, 0, 0, 1);
    do_frame(0, 0, 0, 1);
    pulse_jump();
    frames = 0;
    while (airborne && frames < 40) begin
      do_frame(0, 0, 0, 1);
      frames++;
    end
    check("midair_landed", airborne, 0);
    for (int i = 0; i < 3; i++) begin
      do_frame(0, 0, 0, 1);
      check("midair_no_rejump", airborne, 0);
    end

    // Jump button held through the landing tick: taken one tick later
    pulse_jump();
    frames = 0;
    while (airborne || frames == 0) begin
      do_frame(0, 0, 1, 1);
      frames++;
      if (frames > 40) break;
    end
    do_frame(0, 0, 0, 1);
    check("held_jump_retaken", state_dbg, 1);
    while (airborne && frames < 80) begin
      do_frame(0, 0, 0, 1);
      frames++;
    end

    // Randomised frames
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 5) == 0) pulse_jump();
      do_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 7) == 0), $urandom_range(1, 6));
    end
    while (airborne && frames < 200) begin
      do_frame(0, 0, 0, 1);
      frames++;
    end

    // Reset while falling through y=250
    pulse_jump();
    frames = 0;
    while (!(y == 250 && state_dbg == 2) && frames < 40) begin
      do_frame(0, 1, 0, 1);
      frames++;
    end
    check("pre_reset_y250", y, 250);
    check("queue_drained", exp_q.size(), 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("midjump_rst_y", y, 300);
    check("midjump_rst_state", state_dbg, 0);
    check("midjump_rst_vel", vel_dbg, 0);
    check("midjump_rst_x", x, 100);
    rst = 0;
    model_reset();
    exp_q.delete();
    do_frame(0, 0, 0, 2);
    check("post_reset_tick_ok", airborne, 0);

    repeat (4) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
